// File: rtl/sleepy_dac_pkg.sv
// Constants and helpers shared by the sample feeder and the delta-sigma DAC it drives.
package sleepy_dac_pkg;

    localparam int DAC_DATA_W = 8;
    localparam logic [DAC_DATA_W-1:0] DAC_IDLE_VAL = 8'h00;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 32'sd0;
        span   = 32'sd1;
        while (span < value) begin
            span   = span * 32'sd2;
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// Valid/ready sample stream from a producer (SPI, regfile, sequencer) into the feeder.
interface dac_sample_feeder_if
    import sleepy_dac_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pointers wrap naturally (DEPTH power of two).
module sample_fifo
    import sleepy_dac_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int LVL_W = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push_s, do_pop_s;

    // Full/empty come only from the registered level, so a push is refused when full even alongside a pop.
    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_q[rd_ptr_q];
    assign level     = level_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers; reset empties the FIFO and clears stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers producer samples and releases one per RATE_DIV clocks to the delta-sigma DAC.
// Define SAMPLE_INTERP_EN for linear interpolation between samples; default is zero-order hold.
module dac_sample_feeder
    import sleepy_dac_pkg::*;
#(
    parameter int                DATA_W   = DAC_DATA_W,
    parameter int                DEPTH    = 4,
    parameter int                RATE_DIV = 256,
    parameter logic [DATA_W-1:0] IDLE_VAL = DAC_IDLE_VAL,
    localparam int               LVL_W    = clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    dac_sample_feeder_if.slave        s,
    output logic [DATA_W-1:0]         data_out,
    output logic [LVL_W-1:0]          level,
    output logic                      underrun
);

    localparam int               TMR_W    = clog2(RATE_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RATE_DIV - 1);

    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] head_s;
    logic              tick_s, full_s, empty_s, push_s, pop_s;

    assign tick_s   = enable && (timer_q == TMR_LAST);
    assign push_s   = s.s_valid && !full_s;
    assign pop_s    = tick_s && !empty_s;
    assign s.s_ready = !full_s;
    assign underrun = tick_s && empty_s;
    assign data_out = data_out_q;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (s.s_data),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    // Sample-period timer; disabling clears it so the next period starts fresh.
    always_comb begin
        timer_d = timer_q;
        if (!enable) begin
            timer_d = '0;
        end else if (tick_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

`ifdef SAMPLE_INTERP_EN
    localparam int PROD_W = DATA_W + TMR_W + 2;

    logic [DATA_W-1:0]        prev_q, prev_d, target_q, target_d;
    logic signed [DATA_W:0]   diff_s;
    logic signed [PROD_W-1:0] prod_s, ramp_s, sum_s;

    // Ramp from prev to target across the period; an empty tick collapses prev onto target (flat output).
    always_comb begin
        prev_d   = prev_q;
        target_d = target_q;
        if (pop_s) begin
            prev_d   = target_q;
            target_d = head_s;
        end else if (tick_s) begin
            prev_d   = target_q;
            target_d = target_q;
        end else begin
            prev_d   = prev_q;
            target_d = target_q;
        end
        // Evaluated on next-state values so data_out_q lines up with timer_q.
        diff_s = $signed({1'b0, target_d}) - $signed({1'b0, prev_d});
        prod_s = $signed({{(TMR_W + 1){diff_s[DATA_W]}}, diff_s})
               * $signed({{(DATA_W + 2){1'b0}}, timer_d});
        ramp_s = prod_s >>> TMR_W;
        sum_s  = $signed({{(TMR_W + 2){1'b0}}, prev_d}) + ramp_s;
        if (!enable) begin
            data_out_d = data_out_q;
        end else if (sum_s[PROD_W-1]) begin
            data_out_d = '0;
        end else if (|sum_s[PROD_W-2:DATA_W]) begin
            data_out_d = '1;
        end else begin
            data_out_d = sum_s[DATA_W-1:0];
        end
    end

    // Interpolation endpoints.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= IDLE_VAL;
            target_q <= IDLE_VAL;
        end else begin
            prev_q   <= prev_d;
            target_q <= target_d;
        end
    end
`else
    // Zero-order hold: take the head sample on each pop, otherwise hold.
    always_comb begin
        if (pop_s) begin
            data_out_d = head_s;
        end else begin
            data_out_d = data_out_q;
        end
    end
`endif

    // Timer and output sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            data_out_q <= IDLE_VAL;
        end else begin
            timer_q    <= timer_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder in its default zero-order-hold build (RATE_DIV=256, DEPTH=4).
module tb_dac_sample_feeder;
    import sleepy_dac_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] data_out;
    logic [2:0] level;
    logic       underrun;
    int         tests_run    = 0;
    int         tests_failed = 0;

    dac_sample_feeder_if #(.DATA_W(8)) sif ();

    dac_sample_feeder #(
        .DATA_W   (8),
        .DEPTH    (4),
        .RATE_DIV (256),
        .IDLE_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .s        (sif.slave),
        .data_out (data_out),
        .level    (level),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until underrun is seen; n = cycles advanced, -1 if it never arrives.
    task automatic wait_underrun(output int n);
        n = -1;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (underrun === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Advance until data_out leaves old; also reports any underrun seen on the way.
    task automatic wait_change(input logic [7:0] old, output int n, output bit saw_ur);
        n = -1;
        saw_ur = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (data_out !== old) begin
                n = i;
                break;
            end
            if (underrun === 1'b1) saw_ur = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data = 8'h00;
        steps(3);
        tests_run++;
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        tests_run++;
        if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests_run++;
        if (sif.s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready: got %b expected 1", sif.s_ready); end
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        rst_n = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_idle_underrun();
        int n;
        wait_underrun(n);
        tests_run++;
        if (n !== 255) begin tests_failed++; $display("FAIL idle_first_underrun: got %0d cycles expected 255", n); end
        tests_run++;
        if (data_out !== 8'h00 || level !== 3'd0) begin tests_failed++; $display("FAIL idle_hold: got data %h level %0d expected 00 and 0", data_out, level); end
        step();
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL idle_underrun_width: got %b expected 0", underrun); end
        wait_underrun(n);
        tests_run++;
        if (n !== 255) begin tests_failed++; $display("FAIL idle_underrun_period: got %0d cycles expected 255 after the pulse", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ur;
        step();
        sif.s_valid = 1'b1;
        sif.s_data = 8'h40; step();
        sif.s_data = 8'h80; step();
        sif.s_data = 8'hC0; step();
        sif.s_valid = 1'b0;
        tests_run++;
        if (level !== 3'd3) begin tests_failed++; $display("FAIL b2b_level: got %0d expected 3", level); end
        wait_change(8'h00, n, ur);
        tests_run++;
        if (n !== 253 || data_out !== 8'h40 || level !== 3'd2) begin tests_failed++; $display("FAIL b2b_first: got %0d cycles data %h level %0d expected 253, 40, 2", n, data_out, level); end
        wait_change(8'h40, n, ur);
        tests_run++;
        if (n !== 256 || data_out !== 8'h80 || ur !== 1'b0) begin tests_failed++; $display("FAIL b2b_second: got %0d cycles data %h underrun %b expected 256, 80, 0", n, data_out, ur); end
        wait_change(8'h80, n, ur);
        tests_run++;
        if (n !== 256 || data_out !== 8'hC0 || level !== 3'd0) begin tests_failed++; $display("FAIL b2b_third: got %0d cycles data %h level %0d expected 256, c0, 0", n, data_out, level); end
        wait_underrun(n);
        tests_run++;
        if (n !== 255 || data_out !== 8'hC0) begin tests_failed++; $display("FAIL b2b_drain: got %0d cycles data %h expected 255, c0", n, data_out); end
    endtask

    task automatic test_full_stall();
        int n;
        bit ur;
        step();
        sif.s_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sif.s_data = 8'(k);
            step();
        end
        sif.s_data = 8'h05;
        tests_run++;
        if (sif.s_ready !== 1'b0 || level !== 3'd4) begin tests_failed++; $display("FAIL full_ready: got ready %b level %0d expected 0, 4", sif.s_ready, level); end
        n = 0;
        while (sif.s_ready !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== 252 || data_out !== 8'h01 || level !== 3'd3) begin tests_failed++; $display("FAIL full_release: got %0d cycles data %h level %0d expected 252, 01, 3", n, data_out, level); end
        step();
        sif.s_valid = 1'b0;
        tests_run++;
        if (level !== 3'd4) begin tests_failed++; $display("FAIL full_fifth_push: got level %0d expected 4", level); end
        wait_change(8'h01, n, ur);
        tests_run++;
        if (n !== 255 || data_out !== 8'h02) begin tests_failed++; $display("FAIL full_order_2: got %0d cycles data %h expected 255, 02", n, data_out); end
        for (int k = 3; k <= 5; k++) begin
            wait_change(8'(k - 1), n, ur);
            tests_run++;
            if (n !== 256 || data_out !== 8'(k) || ur !== 1'b0) begin tests_failed++; $display("FAIL full_order_%0d: got %0d cycles data %h underrun %b expected 256, %h, 0", k, n, data_out, ur, 8'(k)); end
        end
        wait_underrun(n);
        tests_run++;
        if (n !== 255 || level !== 3'd0) begin tests_failed++; $display("FAIL full_no_dup: got %0d cycles level %0d expected 255, 0", n, level); end
    endtask

    task automatic test_push_on_underrun_tick();
        int n;
        bit ur;
        sif.s_valid = 1'b1;
        sif.s_data = 8'h5A;
        tests_run++;
        if (underrun !== 1'b1 || sif.s_ready !== 1'b1) begin tests_failed++; $display("FAIL tick_push_underrun: got underrun %b ready %b expected 1, 1", underrun, sif.s_ready); end
        step();
        sif.s_valid = 1'b0;
        tests_run++;
        if (data_out !== 8'h05 || level !== 3'd1) begin tests_failed++; $display("FAIL tick_push_no_bypass: got data %h level %0d expected 05, 1", data_out, level); end
        wait_change(8'h05, n, ur);
        tests_run++;
        if (n !== 256 || data_out !== 8'h5A) begin tests_failed++; $display("FAIL tick_push_later: got %0d cycles data %h expected 256, 5a", n, data_out); end
    endtask

    task automatic test_enable_and_reset();
        int n;
        bit ur;
        bit moved;
        sif.s_valid = 1'b1;
        sif.s_data = 8'h11; step();
        sif.s_data = 8'h22; step();
        sif.s_valid = 1'b0;
        wait_change(8'h5A, n, ur);
        tests_run++;
        if (n !== 254 || data_out !== 8'h11 || level !== 3'd1) begin tests_failed++; $display("FAIL en_first: got %0d cycles data %h level %0d expected 254, 11, 1", n, data_out, level); end
        steps(50);
        enable = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data = 8'h33;
        step();
        sif.s_valid = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (data_out !== 8'h11 || underrun !== 1'b0) moved = 1'b1;
        end
        tests_run++;
        if (moved !== 1'b0 || level !== 3'd2) begin tests_failed++; $display("FAIL en_frozen: got moved %b level %0d expected 0, 2", moved, level); end
        enable = 1'b1;
        wait_change(8'h11, n, ur);
        tests_run++;
        if (n !== 256 || data_out !== 8'h22) begin tests_failed++; $display("FAIL en_resume: got %0d cycles data %h expected 256, 22", n, data_out); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (data_out !== 8'h00 || level !== 3'd0 || sif.s_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset: got data %h level %0d ready %b expected 00, 0, 1", data_out, level, sif.s_ready); end
        step();
        rst_n = 1'b1;
        wait_underrun(n);
        tests_run++;
        if (n !== 255 || data_out !== 8'h00) begin tests_failed++; $display("FAIL midreset_discard: got %0d cycles data %h expected 255, 00", n, data_out); end
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_back_to_back();
        test_full_stall();
        test_push_on_underrun_tick();
        test_enable_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
